// File: rtl/vga_sync_receiver_pkg.sv
// Shared timing defaults, lock FSM encoding and CRC helper for the mini-VGA
// receiver. The timing values match the ones the VGA generator is built with.
package vga_sync_receiver_pkg;

    localparam int H_TOTAL_DEF    = 800;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BACK_DEF     = 48;
    localparam int H_VISIBLE_DEF  = 640;
    localparam int V_TOTAL_DEF    = 525;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BACK_DEF     = 33;
    localparam int V_VISIBLE_DEF  = 480;
    localparam logic SYNC_ACT_DEF = 1'b0;
    localparam int LOCK_LINES_DEF = 4;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_HLOCK    = 2'd1,
        ST_LOCKED   = 2'd2
    } rx_state_t;

    // One bit of CRC-16-CCITT (poly 0x1021), MSB-first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Input register plus leading-edge detector for one sync line. The register
// and its delayed copy both reset to the inactive level so no edge is seen
// coming out of reset.
module vga_sync_edge
    import vga_sync_receiver_pkg::*;
#(
    parameter logic ACT = SYNC_ACT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic lead_edge
);

    logic sync_reg;
    logic sync_dly_reg;

    // Register the raw sync and keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= ~ACT;
            sync_dly_reg <= ~ACT;
        end else begin
            sync_reg     <= sync_in;
            sync_dly_reg <= sync_reg;
        end
    end

    assign lead_edge = (sync_reg == ACT) && (sync_dly_reg != ACT);

endmodule

// File: rtl/vga_sync_receiver.sv
// Mini-VGA receiver: recovers pixel coordinates from hsync/vsync/pixel,
// checks line and frame length and reports lock.
// Optional build macro VGA_RX_CRC_EN adds frame_crc (CRC-16-CCITT over the
// visible pixels of the previous frame).
// Pipeline: input regs -> counters/aligned pixel -> output regs, so a pixel
// captured at edge N is presented with pix_valid at edge N+2.
module vga_sync_receiver
    import vga_sync_receiver_pkg::*;
#(
    parameter int   H_TOTAL    = H_TOTAL_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BACK     = H_BACK_DEF,
    parameter int   H_VISIBLE  = H_VISIBLE_DEF,
    parameter int   V_TOTAL    = V_TOTAL_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BACK     = V_BACK_DEF,
    parameter int   V_VISIBLE  = V_VISIBLE_DEF,
    parameter logic SYNC_ACT   = SYNC_ACT_DEF,
    parameter int   LOCK_LINES = LOCK_LINES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       pixel,
    output logic       locked,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_data,
    output logic       frame_start,
    output logic       err_hlen,
    output logic       err_vlen
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    localparam int H_OFF = H_SYNC + H_BACK;
    localparam int V_OFF = V_SYNC + V_BACK;
    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

    logic [1:0]        sync_in_vec;
    logic [1:0]        edge_vec;
    logic              hedge;
    logic              vedge;
    logic              pix_in_reg;
    logic              pix_d_reg;
    logic [HCNT_W-1:0] hcnt_reg;
    logic [VCNT_W-1:0] vcnt_reg;
    logic              hseen_reg;
    logic              vseen_reg;
    logic [HCNT_W:0]   hlen;
    logic [VCNT_W:0]   vlen;
    logic              line_good;
    logic              line_bad;
    logic              frame_good;
    logic              frame_bad;
    logic              h_vis;
    logic              v_vis;
    rx_state_t         state_reg;
    rx_state_t         state_next;
    logic [7:0]        good_cnt_reg;
    logic              pix_valid_reg;
    logic [9:0]        pix_x_reg;
    logic [9:0]        pix_y_reg;
    logic              pix_data_reg;
    logic              frame_start_reg;
    logic              err_hlen_reg;
    logic              err_vlen_reg;

    // Bit 0 is hsync, bit 1 is vsync; both share the same detector.
    assign sync_in_vec = {vsync, hsync};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            vga_sync_edge #(
                .ACT(SYNC_ACT)
            ) u_edge (
                .clk      (clk),
                .rst_n    (rst_n),
                .sync_in  (sync_in_vec[gi]),
                .lead_edge(edge_vec[gi])
            );
        end
    endgenerate

    assign hedge = edge_vec[0];
    assign vedge = edge_vec[1];

    // Pixel goes through the input register and one alignment stage so it
    // lines up with hcnt_reg/vcnt_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_in_reg <= 1'b0;
            pix_d_reg  <= 1'b0;
        end else begin
            pix_in_reg <= pixel;
            pix_d_reg  <= pix_in_reg;
        end
    end

    // Length of the line/frame just finished, measured at the closing edge.
    // The first edge after reset has no valid start point and is not judged.
    assign hlen       = {1'b0, hcnt_reg} + 1'b1;
    assign vlen       = {1'b0, vcnt_reg} + 1'b1;
    assign line_good  = hedge && hseen_reg && (hlen == (HCNT_W+1)'(H_TOTAL));
    assign line_bad   = hedge && hseen_reg && (hlen != (HCNT_W+1)'(H_TOTAL));
    assign frame_good = vedge && vseen_reg && (vlen == (VCNT_W+1)'(V_TOTAL));
    assign frame_bad  = vedge && vseen_reg && (vlen != (VCNT_W+1)'(V_TOTAL));

    // Saturating line/frame position counters; a stuck sync parks them at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_reg  <= '0;
            vcnt_reg  <= '0;
            hseen_reg <= 1'b0;
            vseen_reg <= 1'b0;
        end else begin
            if (hedge) begin
                hcnt_reg <= '0;
            end else if (hcnt_reg != HCNT_MAX) begin
                hcnt_reg <= hcnt_reg + 1'b1;
            end
            if (vedge) begin
                vcnt_reg <= '0;
            end else if (hedge && (vcnt_reg != VCNT_MAX)) begin
                vcnt_reg <= vcnt_reg + 1'b1;
            end
            if (hedge) hseen_reg <= 1'b1;
            if (vedge) vseen_reg <= 1'b1;
        end
    end

    assign h_vis = (hcnt_reg >= HCNT_W'(H_OFF)) && (hcnt_reg < HCNT_W'(H_OFF + H_VISIBLE));
    assign v_vis = (vcnt_reg >= VCNT_W'(V_OFF)) && (vcnt_reg < VCNT_W'(V_OFF + V_VISIBLE));

    // Lock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_UNLOCKED;
        else        state_reg <= state_next;
    end

    // Lock progression; an error pulse from any state drops lock.
    always_comb begin
        state_next = state_reg;
        if (err_hlen_reg || err_vlen_reg) begin
            state_next = ST_UNLOCKED;
        end else begin
            case (state_reg)
                ST_UNLOCKED: if (line_good && (good_cnt_reg == 8'(LOCK_LINES - 1))) state_next = ST_HLOCK;
                ST_HLOCK:    if (frame_good) state_next = ST_LOCKED;
                ST_LOCKED:   state_next = ST_LOCKED;
                default:     state_next = ST_UNLOCKED;
            endcase
        end
    end

    // FSM-derived output.
    always_comb begin
        locked = (state_reg == ST_LOCKED);
    end

    // Consecutive good lines seen while unlocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_reg <= '0;
        end else if (err_hlen_reg || err_vlen_reg || (state_reg != ST_UNLOCKED)) begin
            good_cnt_reg <= '0;
        end else if (line_good) begin
            good_cnt_reg <= good_cnt_reg + 1'b1;
        end
    end

    // Registered pixel, event and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_reg   <= 1'b0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            pix_data_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            err_hlen_reg    <= 1'b0;
            err_vlen_reg    <= 1'b0;
        end else begin
            pix_valid_reg   <= locked && h_vis && v_vis;
            if (locked && h_vis && v_vis) begin
                pix_x_reg    <= 10'(hcnt_reg - HCNT_W'(H_OFF));
                pix_y_reg    <= vcnt_reg - VCNT_W'(V_OFF);
                pix_data_reg <= pix_d_reg;
            end
            frame_start_reg <= vedge && locked;
            err_hlen_reg    <= line_bad;
            err_vlen_reg    <= frame_bad;
        end
    end

    assign pix_valid   = pix_valid_reg;
    assign pix_x       = pix_x_reg;
    assign pix_y       = pix_y_reg;
    assign pix_data    = pix_data_reg;
    assign frame_start = frame_start_reg;
    assign err_hlen    = err_hlen_reg;
    assign err_vlen    = err_vlen_reg;

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_run_reg;
    logic [15:0] frame_crc_reg;

    // Running CRC over visible pixels; published and restarted at frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_run_reg   <= 16'hFFFF;
            frame_crc_reg <= 16'h0000;
        end else if (frame_start_reg) begin
            frame_crc_reg <= crc_run_reg;
            crc_run_reg   <= 16'hFFFF;
        end else if (pix_valid_reg) begin
            crc_run_reg   <= crc16_step(crc_run_reg, pix_data_reg);
        end
    end

    assign frame_crc = frame_crc_reg;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver with a shrunken raster (20x12 clocks)
// so each frame is 240 cycles. Inputs are driven 1 time unit after posedge,
// outputs sampled on negedge. Pattern: pixel=1 only at the two raster corners.
module tb_vga_sync_receiver;

    localparam int   HT = 20, HS = 2, HB = 3, HV = 12;
    localparam int   VT = 12, VS = 1, VB = 2, VV = 8;
    localparam int   LL = 4;
    localparam int   HOFF = HS + HB;
    localparam int   VOFF = VS + VB;
    localparam logic ACT = 1'b0;
    localparam logic INACT = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic       pixel = 1'b0;
    logic       locked, pix_valid, pix_data, frame_start, err_hlen, err_vlen;
    logic [9:0] pix_x, pix_y;
`ifdef VGA_RX_CRC_EN
    logic [15:0] frame_crc;
`endif

    int n_chk = 0, n_bad = 0;
    int cyc = 0;
    int pv_total = 0, ones_total = 0, n_hlen = 0, n_vlen = 0, n_fs = 0;
    int hlen_cyc = 0, fall_cyc = 0, rise_cyc = 0, drv00_cyc = 0, out00_cyc = 0;
    int ras_idx = 0;
    logic locked_prev = 1'b0;

    vga_sync_receiver #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV),
        .SYNC_ACT(ACT), .LOCK_LINES(LL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .pixel      (pixel),
        .locked     (locked),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_data   (pix_data),
        .frame_start(frame_start),
        .err_hlen   (err_hlen),
        .err_vlen   (err_vlen)
`ifdef VGA_RX_CRC_EN
        ,
        .frame_crc  (frame_crc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pat(input int x, input int y);
        return ((x == 0 && y == 0) || (x == HV - 1 && y == VV - 1)) ? 1 : 0;
    endfunction

    function automatic int crc_frame_exp();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int y = 0; y < VV; y++) begin
            for (int x = 0; x < HV; x++) begin
                fb = c[15] ^ (pat(x, y) == 1);
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return int'(c);
    endfunction

    // Per-cycle observation: raster-order pixel checks plus event counting.
    task automatic observe();
        if (vsync == ACT) ras_idx = 0;
        if (pix_valid) begin
            chk("pv_while_locked", int'(locked), 1);
            chk("pix_x", int'(pix_x), ras_idx % HV);
            chk("pix_y", int'(pix_y), ras_idx / HV);
            chk("pix_data", int'(pix_data), pat(ras_idx % HV, ras_idx / HV));
            if (ras_idx == 0) out00_cyc = cyc;
            ras_idx++;
            pv_total++;
            if (pix_data) ones_total++;
        end
        if (err_hlen) begin
            n_hlen++;
            hlen_cyc = cyc;
        end
        if (err_vlen) n_vlen++;
        if (frame_start) n_fs++;
        if (locked && !locked_prev) rise_cyc = cyc;
        if (!locked && locked_prev) fall_cyc = cyc;
        locked_prev = locked;
    endtask

    task automatic tick(input logic h, input logic v, input logic p);
        hsync = h;
        vsync = v;
        pixel = p;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic gen_line(input int gy, input int from, input int to);
        int   x, y;
        logic h, v, p;
        for (int gx = from; gx < to; gx++) begin
            h = (gx < HS) ? ACT : INACT;
            v = (gy < VS) ? ACT : INACT;
            x = gx - HOFF;
            y = gy - VOFF;
            p = 1'b0;
            if (x >= 0 && x < HV && y >= 0 && y < VV) begin
                p = (pat(x, y) == 1);
                if (x == 0 && y == 0) drv00_cyc = cyc;
            end
            tick(h, v, p);
        end
    endtask

    task automatic gen_frame(input int nlines, input int short_at);
        for (int gy = 0; gy < nlines; gy++) begin
            gen_line(gy, 0, (gy == short_at) ? HT - 1 : HT);
        end
    endtask

    initial begin
        int s_pv, s_ones, s_hlen, s_vlen, s_fs, f2;

        @(posedge clk);
        #1;
        repeat (3) tick(INACT, INACT, 1'b0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_y", int'(pix_y), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_err_hlen", int'(err_hlen), 0);
        chk("rst_err_vlen", int'(err_vlen), 0);
        rst_n = 1'b1;

        // Three clean frames: lock at the second vsync edge, no errors.
        s_pv = pv_total; s_ones = ones_total; s_hlen = n_hlen; s_vlen = n_vlen; s_fs = n_fs;
        gen_frame(VT, -1);
        f2 = cyc;
        gen_frame(VT, -1);
        gen_frame(VT, -1);
        chk("t1_locked", int'(locked), 1);
        chk("t1_lock_rise_delay", rise_cyc - f2, 2);
        chk("t1_err_hlen", n_hlen - s_hlen, 0);
        chk("t1_err_vlen", n_vlen - s_vlen, 0);
        chk("t1_frame_start", n_fs - s_fs, 1);
        chk("t1_pix_valid_cnt", pv_total - s_pv, 2 * HV * VV);
        chk("t1_ones_cnt", ones_total - s_ones, 4);
        chk("t1_latency", out00_cyc - drv00_cyc, 3);
`ifdef VGA_RX_CRC_EN
        chk("t1_frame_crc", int'(frame_crc), crc_frame_exp());
`endif

        // One short line while locked.
        s_hlen = n_hlen; s_vlen = n_vlen;
        gen_frame(VT, 4);
        chk("t2_err_hlen", n_hlen - s_hlen, 1);
        chk("t2_unlock_delay", fall_cyc - hlen_cyc, 1);
        chk("t2_unlocked", int'(locked), 0);
        s_pv = pv_total; s_ones = ones_total;
        gen_frame(VT, -1);
        chk("t2_relocked", int'(locked), 1);
        chk("t2_err_vlen", n_vlen - s_vlen, 0);
        chk("t2_err_hlen_total", n_hlen - s_hlen, 1);
        chk("t2_pix_valid_cnt", pv_total - s_pv, HV * VV);

        // One frame short by a line.
        s_hlen = n_hlen; s_vlen = n_vlen;
        gen_frame(VT - 1, -1);
        gen_frame(VT, -1);
        chk("t3_err_vlen", n_vlen - s_vlen, 1);
        chk("t3_unlocked", int'(locked), 0);
        s_pv = pv_total; s_ones = ones_total;
        gen_frame(VT, -1);
        chk("t3_relocked", int'(locked), 1);
        chk("t3_err_hlen", n_hlen - s_hlen, 0);
        chk("t3_pix_valid_cnt", pv_total - s_pv, HV * VV);
        chk("t3_ones_cnt", ones_total - s_ones, 2);

        // Asynchronous reset in the middle of a visible line.
        s_hlen = n_hlen; s_vlen = n_vlen;
        for (int gy = 0; gy < 5; gy++) gen_line(gy, 0, HT);
        gen_line(5, 0, HOFF + 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_locked", int'(locked), 0);
        chk("t5_async_pix_valid", int'(pix_valid), 0);
        chk("t5_async_pix_x", int'(pix_x), 0);
        chk("t5_async_pix_y", int'(pix_y), 0);
        chk("t5_async_pix_data", int'(pix_data), 0);
        gen_line(5, HOFF + 5, HOFF + 8);
        rst_n = 1'b1;
        gen_line(5, HOFF + 8, HT);
        for (int gy = 6; gy < VT; gy++) gen_line(gy, 0, HT);
        gen_frame(VT, -1);
        chk("t5_not_yet_locked", int'(locked), 0);
        gen_frame(VT, -1);
        chk("t5_relocked", int'(locked), 1);
        chk("t5_err_hlen", n_hlen - s_hlen, 0);
        chk("t5_err_vlen", n_vlen - s_vlen, 0);

        // Both syncs stuck inactive long enough to saturate the line counter.
        s_hlen = n_hlen; s_vlen = n_vlen;
        repeat (2100) tick(INACT, INACT, 1'b0);
        chk("t6_stuck_err_hlen", n_hlen - s_hlen, 0);
        chk("t6_stuck_locked", int'(locked), 1);
        gen_frame(VT, -1);
        chk("t6_resume_err_hlen", n_hlen - s_hlen, 1);
        chk("t6_resume_err_vlen", n_vlen - s_vlen, 0);
        chk("t6_resume_unlocked", int'(locked), 0);
        gen_frame(VT, -1);
        chk("t6_relocked", int'(locked), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
        $finish;
    end

endmodule
